// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I funct3 encodings,
// the controller state enum and the lane-select encodings used by lsu_lane.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; funct3[2] marks an unsigned load.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic       LANE_H_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MERGE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends a load lane, or merges a store
// lane into a word. MERGE selects which result drives the output.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;
    logic [31:0] merged;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        byte_sel  = word[7:0];
        extracted = word;
        merged    = data;
        case (lane)
            LANE_B1: byte_sel = word[15:8];
            LANE_B2: byte_sel = word[23:16];
            LANE_B3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = (lane[1] == LANE_H_HI) ? word[31:16] : word[15:0];

        case (funct3[1:0])
            SZ_B: begin
                extracted = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged    = word;
                case (lane)
                    LANE_B0: merged[7:0]   = data[7:0];
                    LANE_B1: merged[15:8]  = data[7:0];
                    LANE_B2: merged[23:16] = data[7:0];
                    default: merged[31:24] = data[7:0];
                endcase
            end
            SZ_H: begin
                extracted = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged    = word;
                if (lane[1] == LANE_H_HI) merged[31:16] = data[15:0];
                else                      merged[15:0]  = data[15:0];
            end
            default: ;
        endcase
    end

    assign result = MERGE ? merged : extracted;

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory: single-access
// loads and word stores, read-modify-write for byte/halfword stores, fault reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e state_q, state_d;

    logic [MEM_ADDR_W-1:0] req_idx, idx_q, mem_idx;
    logic [1:0]            lane_q;
    logic [2:0]            funct3_q;
    logic [31:0]           wdata_q, merge_q;
    logic [31:0]           load_data, merged_word;
    logic                  f3_legal, misaligned, out_of_range, req_fault, accept;

    assign req_idx      = req_addr[MEM_ADDR_W+1:2];
    assign out_of_range = |req_addr[31:MEM_ADDR_W+2];
    assign req_fault    = !f3_legal || misaligned || out_of_range;
    assign accept       = (state_q == ST_IDLE) && req_valid;
    assign mem_addr     = {{(32-MEM_ADDR_W){1'b0}}, mem_idx};

    always_comb begin
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !req_write;
            default:          f3_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            SZ_H:    misaligned = req_addr[0];
            F3_W[1:0]: misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    lsu_lane #(.MERGE(1'b0)) u_extract (
        .word   (mem_rdata),
        .lane   (req_addr[1:0]),
        .funct3 (req_funct3),
        .data   (req_wdata),
        .result (load_data)
    );

    lsu_lane #(.MERGE(1'b1)) u_merge (
        .word   (merge_q),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .data   (wdata_q),
        .result (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    busy    = 1'b1;
                    state_d = ST_RESP;
                    if (!req_fault) begin
                        mem_idx = req_idx;
                        if (!req_write) begin
                            mem_read = 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            mem_write = 1'b1;
                            mem_wdata = req_wdata;
                        end else begin
                            mem_read = 1'b1;
                            state_d  = ST_MERGE;
                        end
                    end
                end
            end
            ST_MERGE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_idx   = idx_q;
                mem_wdata = merged_word;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep the memory quiet while reset is held, even with a request pending.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_idx   = '0;
            mem_wdata = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            // NOTE: the request/merge registers are reset too; they are few and it keeps outputs deterministic.
            idx_q      <= '0;
            lane_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                resp_fault <= req_fault;
                if (!req_fault && !req_write) resp_rdata <= load_data;
                if (!req_fault && req_write && req_funct3 != F3_W) begin
                    merge_q  <= mem_rdata;
                    idx_q    <= req_idx;
                    lane_q   <= req_addr[1:0];
                    funct3_q <= req_funct3;
                    wdata_q  <= req_wdata;
                end
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and the word-addressed `data_memory`. It converts RV32I loads and stores (byte, halfword, word) into word accesses.
- Loads: selects and sign- or zero-extends the addressed lane.
- Sub-word stores: a two-access read-modify-write.
- Faults: misaligned, illegal, and out-of-range accesses are reported without touching memory.

The core stalls while `busy` is high.

## Interface
- `MEM_ADDR_W`, 6: word-index width of the data memory (64 words).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: access request; sampled only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; held until the next response.
- `resp_fault` output 1: access faulted; qualified by `resp_valid`.
- `busy` output 1: high whenever a request is being processed.
- `mem_read` output 1: memory read enable.
- `mem_write` output 1: memory write enable.
- `mem_addr` output 32: word index; bits above `MEM_ADDR_W` are 0.
- `mem_wdata` output 32: full word to write.
- `mem_rdata` input 32: combinational read data from memory.

## Operation
- States: IDLE, MERGE, RESP.
- IDLE with `req_valid` high: decode the request in the same cycle.
  - Fault conditions: illegal funct3; misalignment (LH/LHU/SH with `addr[0]`=1, LW/SW with `addr[1:0]`≠0); or `addr[31:2]` ≥ 2^MEM_ADDR_W.
  - On fault: no memory enable is asserted, latch `resp_fault`=1, go to RESP.
  - Load: assert `mem_read` and `mem_addr`=`addr[31:2]`. Extract lane `addr[1:0]` from `mem_rdata`, extend it, latch into `resp_rdata`, go to RESP.
  - SW: assert `mem_write` with `mem_wdata`=`req_wdata`, go to RESP.
  - SB/SH: assert `mem_read`, latch `mem_rdata` into a merge register, and latch the address, lane, and store data. Go to MERGE.
- MERGE: assert `mem_write` at the latched address. The write data is the merge register with the addressed byte or halfword lane replaced. Go to RESP.
- RESP: pulse `resp_valid`, then return to IDLE. `req_valid` is ignored in this state.
- Request holding:
  - The core holds the request stable from acceptance through RESP.
  - A `req_valid` still high in the IDLE cycle after RESP is a new request.
- `resp_fault` and `resp_rdata` are updated only when a new response is latched. A store leaves `resp_rdata` unchanged.
- `busy` = `req_valid` in IDLE, or any of MERGE or RESP.
- Memory-side outputs are 0 in IDLE without a request, in RESP, and while `rst` is high.

## Timing
- Reset values: state IDLE. `resp_valid`, `resp_rdata`, `resp_fault`, `busy` (with `req_valid` low), `mem_read`, `mem_write`, `mem_addr`, and `mem_wdata` are all 0.
- Latency from the accepting edge to `resp_valid`:
  - Loads, SW, faults: accepted at edge N, `resp_valid` high during cycle N+1.
  - SB/SH: read in cycle N, write in cycle N+1, `resp_valid` in cycle N+2.
- Memory writes commit on the rising edge that ends a `mem_write` cycle.
- Asynchronous reset during MERGE: state returns to IDLE immediately and `mem_write` drops before the next edge, so no partial write occurs.
- Back-to-back throughput: at most one request every 2 cycles (loads, SW) or 3 cycles (SB/SH).

## Structure
- `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum (`ST_IDLE`, `ST_MERGE`, `ST_RESP`).
  - Lane-select helper constants.
- Sub-module `lsu_lane`: combinational.
  - Extract plus sign/zero-extend for loads.
  - Byte/halfword lane merge for stores.
  - Instantiated once for extract and once for merge.
- The top level holds the FSM, the request/merge registers, and the memory-side drive.

## Test plan
- Memory word 3 = 0x80F1_7F02:
  - LB @0x0E → `resp_rdata`=0xFFFF_FFF1.
  - LBU @0x0E → 0x0000_00F1.
  - LH @0x0E → 0xFFFF_80F1.
  - LW @0x0C → 0x80F1_7F02.
  - Each has `resp_valid` one cycle after acceptance.
- Memory word 5 = 0x1122_3344:
  - SB 0xAB @0x15 → word 5 = 0x1122_AB44.
  - Then SH 0xCDEF @0x16 → 0xCDEF_AB44.
  - Read in cycle N, write in N+1, `resp_valid` in N+2.
- Faults, each with `resp_fault`=1 and no `mem_read`/`mem_write` pulse:
  - LW @0x0D.
  - SH @0x21.
  - LW @0x100 (index 64).
  - funct3=011.
- SW 0xDEAD_BEEF @0x00, then LW @0x00 with `req_valid` held across RESP → `resp_rdata`=0xDEAD_BEEF. The second request is accepted only in the IDLE cycle after RESP.
- Assert `rst` mid-MERGE during SB @0x08 → `mem_write` drops the same cycle and word 2 is unchanged. All outputs read their reset values while `rst` is high.
